// File: rtl/memory_dump_reader_pkg.sv
// memory_dump_reader_pkg: state encoding and default widths shared by the dump reader and its bench
package memory_dump_reader_pkg;
    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_e;
endpackage

// File: rtl/memory_dump_reader_if.sv
// memory_dump_reader_if: control, memory read port and output stream of the dump reader
interface memory_dump_reader_if
    import memory_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_address;
    logic [ADDR_WIDTH-1:0] end_address;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    modport master (
        input  start, start_address, end_address, mem_data, out_ready,
        output mem_address, mem_read, out_data, out_valid, busy, done
    );
    modport slave (
        output start, start_address, end_address, mem_data, out_ready,
        input  mem_address, mem_read, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/memory_dump_reader.sv
// memory_dump_reader: streams an inclusive, wrapping address range of memory out over valid/ready
module memory_dump_reader
    import memory_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input logic                 clk,
    input logic                 reset,
    memory_dump_reader_if.master bus
);
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    // cur_addr only moves on entry to ISSUE, so it doubles as the memory address register
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        last_addr_d = last_addr_q;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d     = ISSUE;
                cur_addr_d  = bus.start_address;
                last_addr_d = bus.end_address;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d    = PRESENT;
                out_data_d = bus.mem_data;
            end
            PRESENT: if (bus.out_ready) begin
                state_d    = (cur_addr_q == last_addr_q) ? DONE : ISSUE;
                cur_addr_d = (cur_addr_q == last_addr_q) ? cur_addr_q : cur_addr_q + ADDR_WIDTH'(1);
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            last_addr_q <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            last_addr_q <= last_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.mem_address = cur_addr_q;
    assign bus.mem_read    = (state_q == ISSUE);
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = (state_q == PRESENT);
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
endmodule

// File: tb/tb_memory_dump_reader.sv
// tb_memory_dump_reader: table-driven dumps against a 1-cycle memory model with a byte scoreboard
module tb_memory_dump_reader;
    import memory_dump_reader_pkg::*;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] sa;
        logic [7:0] ea;
        int         stall;
        bit         restart;
        int         exp_bytes;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    memory_dump_reader_if bus ();
    memory_dump_reader dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] mem [256];
    always @(posedge clk) if (bus.mem_read) bus.mem_data <= mem[bus.mem_address];

    exp_t sb[$];
    int   checks = 0, passes = 0, cyc = 0;
    int   xfers = 0, dones = 0, last_xfer_cyc = 0, stall_left = 0;
    bit   prev_mem_read = 1'b0, chk_gap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transfers and stalls are judged on what was on the bus just before the edge
    task automatic tick();
        bit         x, hp;
        logic [7:0] d, a;
        exp_t       e;
        x  = bus.out_valid && bus.out_ready && !reset;
        hp = bus.out_valid && !bus.out_ready && !reset;
        d  = bus.out_data;
        a  = bus.mem_address;
        @(negedge clk);
        cyc++;
        if (x) begin
            check("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("xfer_data", d, e.data);
                check("xfer_addr", a, e.addr);
                if (chk_gap && xfers > 0) check("xfer_gap", cyc - 1 - last_xfer_cyc, 3);
                last_xfer_cyc = cyc - 1;
                xfers++;
            end
        end
        if (hp) begin
            check("hold_valid", bus.out_valid, 1);
            check("hold_data", bus.out_data, d);
            check("hold_no_read", bus.mem_read, 0);
        end
        if (bus.mem_read) begin
            check("read_gap", prev_mem_read, 0);
            if (sb.size() != 0) check("issue_addr", bus.mem_address, sb[0].addr);
        end
        prev_mem_read = bus.mem_read;
        if (bus.done) begin
            check("done_after_last", cyc - last_xfer_cyc, 1);
            check("done_sb_empty", sb.size(), 0);
            dones++;
        end
    endtask

    task automatic push_range(input logic [7:0] sa, input logic [7:0] ea);
        logic [7:0] a;
        a = sa;
        forever begin
            sb.push_back('{addr: a, data: mem[a]});
            if (a == ea) break;
            a++;
        end
    endtask

    task automatic run_dump(input vec_t v);
        int d0;
        d0 = dones;
        xfers = 0;
        stall_left = v.stall;
        chk_gap = (v.stall == 0);
        push_range(v.sa, v.ea);
        bus.out_ready = (stall_left == 0);
        bus.start = 1'b1;
        bus.start_address = v.sa;
        bus.end_address = v.ea;
        tick();
        check("issue_busy", bus.busy, 1);
        check("issue_read", bus.mem_read, 1);
        bus.start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            bus.out_ready = (stall_left == 0);
            if (bus.out_valid && stall_left > 0) stall_left--;
            bus.start = v.restart && (k == 4);
            if (bus.start) begin
                bus.start_address = 8'h40;
                bus.end_address = 8'h41;
            end
            if (dones != d0) break;
        end
        bus.start = 1'b0;
        check("done_count", dones - d0, 1);
        check("byte_count", xfers, v.exp_bytes);
        tick();
        check("busy_after_done", bus.busy, 0);
        check("done_one_cycle", bus.done, 0);
    endtask

    vec_t vecs[5];

    initial begin
        int d0;
        vecs[0] = '{sa: 8'h00, ea: 8'h02, stall: 0, restart: 1'b0, exp_bytes: 3};
        vecs[1] = '{sa: 8'h01, ea: 8'h01, stall: 0, restart: 1'b0, exp_bytes: 1};
        vecs[2] = '{sa: 8'h10, ea: 8'h12, stall: 5, restart: 1'b0, exp_bytes: 3};
        vecs[3] = '{sa: 8'h20, ea: 8'h22, stall: 0, restart: 1'b1, exp_bytes: 3};
        vecs[4] = '{sa: 8'hFD, ea: 8'h02, stall: 0, restart: 1'b0, exp_bytes: 6};
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        reset = 1'b1;
        bus.start = 1'b0;
        bus.start_address = '0;
        bus.end_address = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        reset = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) run_dump(vecs[i]);

        mem[8'hFE] = 8'hAA;
        mem[8'hFF] = 8'hBB;
        mem[8'h00] = 8'hCC;
        run_dump('{sa: 8'hFE, ea: 8'h00, stall: 0, restart: 1'b0, exp_bytes: 3});

        // Abort while the second byte is being presented
        d0 = dones;
        xfers = 0;
        chk_gap = 1'b0;
        push_range(8'h30, 8'h33);
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        bus.start_address = 8'h30;
        bus.end_address = 8'h33;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            bus.out_ready = bus.out_valid && (xfers == 0);
            if (xfers == 1 && bus.out_valid) break;
        end
        check("abort_reached_byte2", 32'(xfers == 1 && bus.out_valid), 1);
        reset = 1'b1;
        tick();
        check("abort_mem_address", bus.mem_address, 0);
        check("abort_mem_read", bus.mem_read, 0);
        check("abort_out_data", bus.out_data, 0);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        reset = 1'b0;
        sb.delete();
        tick();
        check("abort_no_done", dones - d0, 0);
        run_dump('{sa: 8'h30, ea: 8'h33, stall: 0, restart: 1'b0, exp_bytes: 4});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
